rpn_program_sequencer: RTL and testbench

- Upstream driver for the 16-bit RPN stack calculator: stores a small program of RPN instructions and replays it, one command per step.
- Produces the calculator's d/push/op command stream, so a whole expression runs from one start pulse.
- Tracks stack depth itself and halts with an error instead of issuing a command that would underflow or overflow the calculator stack.

---
 rtl/rpn_program_sequencer.sv | 156 +++++++++++++++
 tb/tb_rpn_program_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_program_sequencer.sv
// Program sequencer for the 16-bit RPN stack calculator: stores RPN instructions and
// replays them as push/op/d commands, tracking stack depth to stop before misuse.
module rpn_program_sequencer #(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned STACK_DEPTH = 1024
) (
    input  logic              step,
    input  logic              nrst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [18:0]       wr_data,
    input  logic              start,
    output logic              push_o,
    output logic [1:0]        op_o,
    output logic [15:0]       d_o,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] pc,
    output logic [10:0]       depth
);

    localparam int unsigned       Words    = 2 ** ADDR_W;
    localparam logic [10:0]       DepthMax = 11'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] PcLast   = {ADDR_W{1'b1}};

    localparam logic [1:0] KindPush = 2'b00;
    localparam logic [1:0] KindOp   = 2'b01;
    localparam logic [1:0] KindNop  = 2'b10;

    typedef enum logic [1:0] {StIdle, StRun, StDone, StErr} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [10:0]       depth_q, depth_d;
    logic              push_q, push_d;
    logic [1:0]        op_q, op_d;
    logic [15:0]       d_q, d_d;
    logic              advance;

    logic [18:0] mem_q [Words];
    logic [18:0] instr;
    logic [1:0]  kind;
    logic [15:0] imm;
    logic [1:0]  instr_op;
    logic        unused_instr;

    assign instr        = mem_q[pc_q];
    assign kind         = instr[18:17];
    assign imm          = instr[15:0];
    assign instr_op     = instr[1:0];
    assign unused_instr = instr[16];

    // Program memory is deliberately not reset so a program survives nrst.
    always_ff @(posedge step) begin
        if (wr_en && state_q != StRun) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        push_d  = 1'b0;
        op_d    = 2'd0;
        d_d     = d_q;
        advance = 1'b0;
        case (state_q)
            StRun: begin
                advance = 1'b1;
                case (kind)
                    KindPush: begin
                        if (depth_q < DepthMax) begin
                            push_d  = 1'b1;
                            d_d     = imm;
                            depth_d = depth_q + 11'd1;
                        end else begin
                            state_d = StErr;
                            advance = 1'b0;
                        end
                    end
                    KindOp: begin
                        case (instr_op)
                            2'd0: op_d = 2'd0;
                            2'd1: begin
                                if (depth_q >= 11'd1) begin
                                    op_d = 2'd1;
                                end else begin
                                    state_d = StErr;
                                    advance = 1'b0;
                                end
                            end
                            default: begin
                                // Binary ops consume two entries and leave one.
                                if (depth_q >= 11'd2) begin
                                    op_d    = instr_op;
                                    depth_d = depth_q - 11'd1;
                                end else begin
                                    state_d = StErr;
                                    advance = 1'b0;
                                end
                            end
                        endcase
                    end
                    KindNop: op_d = 2'd0;
                    default: begin
                        state_d = StDone;
                        advance = 1'b0;
                    end
                endcase
                if (advance) begin
                    if (pc_q == PcLast) begin
                        state_d = StDone;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = StRun;
                    pc_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge step or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            depth_q <= '0;
            push_q  <= 1'b0;
            op_q    <= 2'd0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            push_q  <= push_d;
            op_q    <= op_d;
            d_q     <= d_d;
        end
    end

    assign push_o = push_q;
    assign op_o   = op_q;
    assign d_o    = d_q;
    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);
    assign error  = (state_q == StErr);
    assign pc     = pc_q;
    assign depth  = depth_q;

endmodule

// File: tb/tb_rpn_program_sequencer.sv
// Scoreboard bench: expected commands are queued by stimulus, a negedge monitor pops
// and compares them and feeds a small calculator model.
module tb_rpn_program_sequencer;

    localparam int ADDR_W = 6;

    logic              step = 1'b0;
    logic              nrst = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [18:0]       wr_data = '0;
    logic              start = 1'b0;
    logic              push_o;
    logic [1:0]        op_o;
    logic [15:0]       d_o;
    logic              busy, done, error;
    logic [ADDR_W-1:0] pc;
    logic [10:0]       depth;

    rpn_program_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(1024)) dut (
        .step(step), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .push_o(push_o), .op_o(op_o), .d_o(d_o), .busy(busy),
        .done(done), .error(error), .pc(pc), .depth(depth)
    );

    always #5 step = ~step;

    int total = 0;
    int bad   = 0;
    logic [18:0] sb [$];     // expected {push, op, d}
    logic [15:0] mstk [$];   // calculator model stack

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] i_push(input logic [15:0] v);
        return {2'b00, 1'b0, v};
    endfunction
    function automatic logic [18:0] i_op(input logic [1:0] o);
        return {2'b01, 15'd0, o};
    endfunction
    localparam logic [18:0] I_NOP  = {2'b10, 17'd0};
    localparam logic [18:0] I_HALT = {2'b11, 17'd0};

    function automatic logic [18:0] c_push(input logic [15:0] v);
        return {1'b1, 2'd0, v};
    endfunction
    function automatic logic [18:0] c_op(input logic [1:0] o);
        return {1'b0, o, 16'd0};
    endfunction

    always @(negedge step) begin
        if (nrst === 1'b1 && (push_o || op_o != 2'd0)) begin
            logic [18:0] act;
            logic [15:0] a, b;
            act = {push_o, op_o, push_o ? d_o : 16'd0};
            if (sb.size() == 0) begin
                chk("unexpected_cmd", {13'd0, act}, 32'd0);
            end else begin
                chk("cmd", {13'd0, act}, {13'd0, sb.pop_front()});
            end
            if (push_o) mstk.push_back(d_o);
            else if (op_o == 2'd1 && mstk.size() >= 1) begin
                a = mstk.pop_back();
                mstk.push_back(-a);
            end else if (mstk.size() >= 2) begin
                a = mstk.pop_back();
                b = mstk.pop_back();
                mstk.push_back(op_o == 2'd2 ? a + b : a * b);
            end
        end
    end

    task automatic load(input logic [18:0] prog [$]);
        foreach (prog[i]) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(i);
            wr_data = prog[i];
            @(posedge step); #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge step); #1;
        start = 1'b0;
    endtask

    // Waits for done/error after a start pulse; counts busy samples.
    task automatic wait_end(input int budget, output int nbusy);
        int n = 0;
        nbusy = busy ? 1 : 0;
        while (!(done || error) && n < budget) begin
            @(posedge step); #1;
            n++;
            if (busy) nbusy++;
        end
        chk("run_timeout", {31'd0, n >= budget}, 32'd0);
        @(negedge step); #1;
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #2;
        sb.delete();
        mstk.delete();
        @(negedge step);
        nrst = 1'b1;
    endtask

    task automatic exp_arith();
        sb.push_back(c_push(16'd3));
        sb.push_back(c_push(16'd4));
        sb.push_back(c_op(2'd2));
        sb.push_back(c_push(16'd5));
        sb.push_back(c_op(2'd3));
    endtask

    initial begin
        int nb;
        logic [18:0] prog [$];

        #12;
        chk("rst_cmd", {13'd0, push_o, op_o, d_o}, 32'd0);
        chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_depth", depth, 32'd0);
        @(negedge step);
        nrst = 1'b1;

        // Arithmetic: (3+4)*5
        prog = '{i_push(16'd3), i_push(16'd4), i_op(2'd2), i_push(16'd5), i_op(2'd3), I_HALT};
        load(prog);
        exp_arith();
        pulse_start();
        chk("arith_busy", busy, 32'd1);
        wait_end(100, nb);
        chk("arith_flags", {done, error}, 32'b10);
        chk("arith_pc", pc, 32'd5);
        chk("arith_depth", depth, 32'd1);
        chk("arith_out", mstk[$], 32'd35);

        // Write during RUN must be ignored
        exp_arith();
        pulse_start();
        wr_en = 1'b1; wr_addr = '0; wr_data = i_push(16'd99);
        @(posedge step); #1;
        wr_en = 1'b0;
        wait_end(100, nb);
        exp_arith();
        pulse_start();
        wait_end(100, nb);
        chk("lock_depth", depth, 32'd3);
        chk("lock_out", mstk[$], 32'd35);

        // Reset mid-run
        exp_arith();
        pulse_start();
        @(posedge step); #1;
        @(posedge step); #1;
        nrst = 1'b0;
        #1;
        chk("midrst_cmd", {13'd0, push_o, op_o, d_o}, 32'd0);
        chk("midrst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("midrst_depth", depth, 32'd0);
        sb.delete();
        mstk.delete();
        @(negedge step);
        nrst = 1'b1;
        repeat (3) @(posedge step);
        #1;
        chk("midrst_idle", {busy, done, error}, 32'd0);
        chk("midrst_pc", pc, 32'd0);
        exp_arith();
        pulse_start();
        wait_end(100, nb);
        chk("rerun_out", mstk[$], 32'd35);
        chk("rerun_depth", depth, 32'd1);

        // Underflow
        do_reset();
        prog = '{i_push(16'd7), i_op(2'd2)};
        load(prog);
        sb.push_back(c_push(16'd7));
        pulse_start();
        wait_end(100, nb);
        chk("uf_flags", {done, error}, 32'b01);
        chk("uf_pc", pc, 32'd1);
        chk("uf_depth", depth, 32'd1);

        // Negate, NOP, persistence
        do_reset();
        prog = '{i_push(16'd5), i_op(2'd1), I_NOP, I_HALT};
        load(prog);
        sb.push_back(c_push(16'd5));
        sb.push_back(c_op(2'd1));
        pulse_start();
        wait_end(100, nb);
        chk("neg_flags", {done, error}, 32'b10);
        chk("neg_pc", pc, 32'd3);
        chk("neg_depth", depth, 32'd1);
        chk("neg_out", mstk[$], 32'hfffb);
        chk("neg_hold_d", d_o, 32'd5);
        sb.push_back(c_push(16'd5));
        sb.push_back(c_op(2'd1));
        pulse_start();
        wait_end(100, nb);
        chk("neg2_depth", depth, 32'd2);
        chk("neg2_out", mstk[$], 32'hfffb);

        // End of memory without HALT
        do_reset();
        prog.delete();
        for (int i = 0; i < 64; i++) prog.push_back(I_NOP);
        load(prog);
        pulse_start();
        wait_end(200, nb);
        chk("eom_busy_cycles", nb, 32'd64);
        chk("eom_flags", {done, error}, 32'b10);
        chk("eom_pc", pc, 32'd63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
